// File: rtl/dv_word_packer.sv
// dv_word_packer: packs PACK_N sampled bytes little-endian into words, flushes partial words
// after an idle timeout, and queues words in a small FIFO with sticky overflow.
module dv_word_packer #(
  parameter int PACK_N  = 4,
  parameter int TIMEOUT = 16,
  parameter int DEPTH   = 4,
  localparam int W      = 8 * PACK_N,
  localparam int LW     = $clog2(PACK_N) + 1
) (
  input  logic          sclk,
  input  logic          rst_n,
  input  logic          i_dv,
  input  logic [7:0]    i_data,
  output logic          o_word_vld,
  output logic [W-1:0]  o_word,
  output logic [LW-1:0] o_word_len,
  input  logic          i_word_rdy,
  output logic          o_ovf,
  input  logic          i_ovf_clr
);
  localparam int CW = $clog2(PACK_N);
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int NW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] LAST_LANE = CW'(PACK_N - 1);
  localparam logic [IW-1:0] TMO_LAST  = IW'(TIMEOUT - 1);
  localparam logic [NW-1:0] FULL      = NW'(DEPTH);

  typedef enum logic {S_IDLE, S_FILL} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_pack_cnt;
  logic [W-1:0]    r_pack_reg;
  logic [IW-1:0]   r_idle_cnt;
  logic [W-1:0]    r_mem_word [DEPTH];
  logic [LW-1:0]   r_mem_len  [DEPTH];
  logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [NW-1:0]   r_count;
  logic            r_ovf;

  logic            w_done, w_tmo, w_push, w_pop, w_wr;
  logic [W-1:0]    w_push_word;
  logic [LW-1:0]   w_push_len;

  assign w_done      = r_state == S_FILL && i_dv && r_pack_cnt == LAST_LANE;
  assign w_tmo       = r_state == S_FILL && !i_dv && r_idle_cnt == TMO_LAST;
  assign w_push      = w_done | w_tmo;
  assign w_push_word = w_done ? {i_data, r_pack_reg[W-9:0]} : r_pack_reg;
  assign w_push_len  = w_done ? LW'(PACK_N) : {1'b0, r_pack_cnt};
  assign w_pop       = r_count != '0 && i_word_rdy;
  assign w_wr        = w_push && (r_count != FULL || w_pop);

  assign o_word_vld  = r_count != '0;
  assign o_word      = r_mem_word[r_rd_ptr];
  assign o_word_len  = r_mem_len[r_rd_ptr];
  assign o_ovf       = r_ovf;

  // A new word starts from a cleared register, so unused upper lanes read as zero on a flush.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pack_cnt <= '0;
      r_pack_reg <= '0;
      r_idle_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      r_idle_cnt <= '0;
      if (i_dv) begin
        r_pack_reg <= {{(W-8){1'b0}}, i_data};
        r_pack_cnt <= CW'(1);
        r_state    <= S_FILL;
      end
    end else if (i_dv) begin
      r_idle_cnt <= '0;
      if (w_done) begin
        r_pack_cnt <= '0;
        r_state    <= S_IDLE;
      end else begin
        r_pack_reg[8*r_pack_cnt +: 8] <= i_data;
        r_pack_cnt <= r_pack_cnt + CW'(1);
      end
    end else if (w_tmo) begin
      r_idle_cnt <= '0;
      r_pack_cnt <= '0;
      r_state    <= S_IDLE;
    end else begin
      r_idle_cnt <= r_idle_cnt + IW'(1);
    end
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_word[i] <= '0;
        r_mem_len[i]  <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem_word[r_wr_ptr] <= w_push_word;
        r_mem_len[r_wr_ptr]  <= w_push_len;
        r_wr_ptr             <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + NW'(w_wr) - NW'(w_pop);
      if (w_push && !w_wr) r_ovf <= 1'b1;
      else if (i_ovf_clr) r_ovf <= 1'b0;
    end
  end
endmodule

// File: tb/tb_dv_word_packer.sv
// tb_dv_word_packer: directed checks of packing, timeout flush, backpressure, overflow,
// reset and pointer wrap; popped words are matched against hand-computed expectations.
module tb_dv_word_packer;
  logic        sclk = 0;
  logic        rst_n = 0;
  logic        i_dv = 0;
  logic [7:0]  i_data = 0;
  logic        o_word_vld;
  logic [31:0] o_word;
  logic [2:0]  o_word_len;
  logic        i_word_rdy = 0;
  logic        o_ovf;
  logic        i_ovf_clr = 0;
  logic        rand_en = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] qw[$];
  logic [2:0]  ql[$];

  dv_word_packer dut (
    .sclk(sclk), .rst_n(rst_n), .i_dv(i_dv), .i_data(i_data),
    .o_word_vld(o_word_vld), .o_word(o_word), .o_word_len(o_word_len),
    .i_word_rdy(i_word_rdy), .o_ovf(o_ovf), .i_ovf_clr(i_ovf_clr)
  );

  always #5 sclk = ~sclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sclk);
    #1;
    if (rand_en) i_word_rdy = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send(input logic [7:0] b);
    i_dv = 1;
    i_data = b;
    step();
    i_dv = 0;
  endtask

  task automatic expect_word(input logic [31:0] w, input logic [2:0] l);
    qw.push_back(w);
    ql.push_back(l);
  endtask

  // A pop happens on the next rising edge whenever valid and ready are both high here.
  always @(negedge sclk) begin
    if (rst_n && o_word_vld && i_word_rdy) begin
      if (qw.size() == 0) chk("pop_unexpected", {32'h0, o_word}, 64'h0);
      else begin
        chk("pop_word", o_word, qw.pop_front());
        chk("pop_len", o_word_len, ql.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    #2;
    chk("rst_vld", o_word_vld, 0);
    chk("rst_word", o_word, 0);
    chk("rst_len", o_word_len, 0);
    chk("rst_ovf", o_ovf, 0);
    step();
    rst_n = 1;
    step();

    // Upstream pattern with idle gaps shorter than the timeout
    i_word_rdy = 1;
    expect_word(32'h05070507, 3'd4);
    expect_word(32'h05070507, 3'd4);
    for (int i = 0; i < 8; i++) begin
      send(i % 2 ? 8'h05 : 8'h07);
      idle(1 + i % 6);
    end
    idle(3);
    chk("pattern_drained", qw.size(), 0);
    chk("pattern_vld", o_word_vld, 0);

    // Timeout flush
    i_word_rdy = 0;
    send(8'hAA);
    send(8'hBB);
    idle(15);
    chk("tmo_early", o_word_vld, 0);
    idle(1);
    chk("tmo_vld", o_word_vld, 1);
    chk("tmo_word", o_word, 32'h0000BBAA);
    chk("tmo_len", o_word_len, 2);
    expect_word(32'h0000BBAA, 3'd2);
    i_word_rdy = 1;
    step();
    i_word_rdy = 0;
    chk("tmo_popped", o_word_vld, 0);

    // Byte at the timeout cycle wins over the flush
    send(8'hAA);
    send(8'hBB);
    idle(15);
    send(8'hCC);
    chk("tmo_suppressed", o_word_vld, 0);
    send(8'hDD);
    chk("cont_vld", o_word_vld, 1);
    chk("cont_word", o_word, 32'hDDCCBBAA);
    chk("cont_len", o_word_len, 4);
    expect_word(32'hDDCCBBAA, 3'd4);
    i_word_rdy = 1;
    idle(2);
    i_word_rdy = 0;
    chk("cont_drained", qw.size(), 0);

    // Backpressure and overflow
    for (int i = 0; i < 20; i++) send(8'(i));
    chk("ovf_head", o_word, 32'h03020100);
    chk("ovf_len", o_word_len, 4);
    chk("ovf_set", o_ovf, 1);
    expect_word(32'h03020100, 3'd4);
    expect_word(32'h07060504, 3'd4);
    expect_word(32'h0B0A0908, 3'd4);
    expect_word(32'h0F0E0D0C, 3'd4);
    i_word_rdy = 1;
    idle(6);
    i_word_rdy = 0;
    chk("ovf_drained", qw.size(), 0);
    chk("ovf_empty", o_word_vld, 0);
    chk("ovf_sticky", o_ovf, 1);
    i_ovf_clr = 1;
    step();
    i_ovf_clr = 0;
    chk("ovf_clr", o_ovf, 0);

    // Full FIFO with pop and push on the completing edge
    for (int i = 0; i < 16; i++) send(8'h20 + 8'(i));
    for (int i = 0; i < 3; i++) send(8'h30 + 8'(i));
    chk("full_no_ovf", o_ovf, 0);
    expect_word(32'h23222120, 3'd4);
    expect_word(32'h27262524, 3'd4);
    expect_word(32'h2B2A2928, 3'd4);
    expect_word(32'h2F2E2D2C, 3'd4);
    expect_word(32'h33323130, 3'd4);
    i_dv = 1;
    i_data = 8'h33;
    i_word_rdy = 1;
    step();
    i_dv = 0;
    i_word_rdy = 0;
    chk("simul_ovf", o_ovf, 0);
    chk("simul_head", o_word, 32'h27262524);
    i_word_rdy = 1;
    idle(4);
    i_word_rdy = 0;
    chk("simul_count4", o_word_vld, 0);
    chk("simul_drained", qw.size(), 0);

    // Reset mid-word with a word queued
    for (int i = 0; i < 4; i++) send(8'hE0 + 8'(i));
    send(8'h11);
    send(8'h22);
    rst_n = 0;
    #1;
    chk("midrst_vld", o_word_vld, 0);
    chk("midrst_word", o_word, 0);
    chk("midrst_len", o_word_len, 0);
    chk("midrst_ovf", o_ovf, 0);
    step();
    rst_n = 1;
    for (int i = 0; i < 4; i++) send(8'h33 + 8'(i * 17));
    chk("postrst_vld", o_word_vld, 1);
    chk("postrst_word", o_word, 32'h66554433);
    chk("postrst_len", o_word_len, 4);
    expect_word(32'h66554433, 3'd4);
    i_word_rdy = 1;
    idle(2);
    i_word_rdy = 0;
    chk("postrst_drained", qw.size(), 0);

    // Pointer wrap with random ready, at most 4 words outstanding
    rand_en = 1;
    for (int w = 0; w < 40; w++) begin
      logic [31:0] ew;
      int n;
      n = 0;
      while (qw.size() >= 4 && n < 200) begin
        step();
        n++;
      end
      chk("wrap_wait", n < 200, 1);
      for (int j = 0; j < 4; j++) ew[8*j +: 8] = 8'(w * 4 + j) ^ 8'h5A;
      expect_word(ew, 3'd4);
      for (int j = 0; j < 4; j++) send(ew[8*j +: 8]);
    end
    rand_en = 0;
    i_word_rdy = 1;
    for (int n = 0; n < 50 && qw.size() != 0; n++) step();
    chk("wrap_drained", qw.size(), 0);
    chk("wrap_ovf", o_ovf, 0);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
